// File: rtl/rot_pkg.sv
// Shared types and constants for the rotate/shift stream stage.
// Op encoding is visible on the stage's input port, so keep it stable.
package rot_pkg;

   typedef enum logic [1:0] {
      ROTL = 2'd0,
      ROTR = 2'd1,
      SHL  = 2'd2,
      SHR  = 2'd3
   } op_t;

   localparam int FIFO_DEPTH = 2;

   // Pointers address a 2-entry buffer, so a single bit each is enough
   localparam int PTR_W = 1;
   localparam int FCNT_W = 2;

endpackage

// File: rtl/rot_core.sv
// Purely combinational multi-function shifter: rotate left/right and logical shift left/right.
// Result width equals operand width; shifts fill with zeros.
module rot_core
   import rot_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic [SHW-1:0]   i_shamt,
   input  op_t              i_op,
   output logic [WIDTH-1:0] o_result
);

   logic [2*WIDTH-1:0] w_dbl;
   logic [2*WIDTH-1:0] w_dblL;
   logic [2*WIDTH-1:0] w_dblR;

   // Rotates shift a doubled copy of the operand so bits wrap without a modulo step
   assign w_dbl  = {i_data, i_data};
   assign w_dblL = w_dbl << i_shamt;
   assign w_dblR = w_dbl >> i_shamt;

   always_comb begin
      o_result = i_data;
      case (i_op)
         ROTL: o_result = w_dblL[2*WIDTH-1:WIDTH];
         ROTR: o_result = w_dblR[WIDTH-1:0];
         SHL:  o_result = i_data << i_shamt;
         SHR:  o_result = i_data >> i_shamt;
         default: o_result = i_data;
      endcase
   end

endmodule

// File: rtl/rot_stream_stage.sv
// Registered valid/ready wrapper around rot_core: one input register (S1) feeding a
// 2-entry output FIFO, plus a free-running count of delivered results.
module rot_stream_stage
   import rot_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  op_t              in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_count
);

   logic             r_s1V;
   logic [WIDTH-1:0] r_s1Data;
   logic [SHW-1:0]   r_s1Shamt;
   op_t              r_s1Op;

   logic [WIDTH-1:0]  r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [FCNT_W-1:0] r_count;
   logic [CNT_W-1:0]  r_outCount;

   logic             w_push;
   logic             w_pop;
   logic             w_advance;
   logic             w_fifoHasRoom;
   logic [WIDTH-1:0] w_coreResult;

   // in_ready depends only on registered state, so out_ready never reaches it combinationally
   assign w_fifoHasRoom = (r_count < FCNT_W'(FIFO_DEPTH));
   assign in_ready      = !r_s1V || w_fifoHasRoom;
   assign w_push        = in_valid && in_ready;
   assign w_advance     = r_s1V && w_fifoHasRoom;
   assign out_valid     = (r_count != '0);
   assign w_pop         = out_valid && out_ready;
   assign out_data      = r_mem[r_rdPtr];
   assign out_count     = r_outCount;

   rot_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .i_data  (r_s1Data),
      .i_shamt (r_s1Shamt),
      .i_op    (r_s1Op),
      .o_result(w_coreResult)
   );

   // A push in the same cycle as an advance refills S1 instead of emptying it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1V     <= 1'b0;
         r_s1Data  <= '0;
         r_s1Shamt <= '0;
         r_s1Op    <= ROTL;
      end else if (w_push) begin
         r_s1V     <= 1'b1;
         r_s1Data  <= in_data;
         r_s1Shamt <= in_shamt;
         r_s1Op    <= in_op;
      end else if (w_advance) begin
         r_s1V     <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_advance) begin
            r_mem[r_wrPtr] <= w_coreResult;
            r_wrPtr        <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_advance, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_outCount <= '0;
      end else if (w_pop) begin
         r_outCount <= r_outCount + 1'b1;
      end
   end

endmodule
